// File: rtl/lift_pkg.sv
// Shared types and constants for the lift call scheduler.
package lift_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MOVE_UP   = 3'd1,
      MOVE_DOWN = 3'd2,
      DOOR      = 3'd3,
      FAULT     = 3'd4
   } lift_state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int NFLOORS_DEF = 8;

endpackage

// File: rtl/lift_call_latch.sv
// Outstanding-call register with set/clear masking and above/below reductions.
module lift_call_latch
   import lift_pkg::*;
#(
   parameter int NFLOORS = NFLOORS_DEF,
   parameter int FLW     = $clog2(NFLOORS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NFLOORS-1:0] call_req,
   input  logic [FLW-1:0]     cur_floor,
   input  logic               ign_en,
   input  logic               clr_en,
   input  logic [FLW-1:0]     clr_idx,
   output logic [NFLOORS-1:0] pending,
   output logic               above,
   output logic               below,
   output logic               above_next,
   output logic               below_next
);

   logic [NFLOORS-1:0] set_mask;
   logic [NFLOORS-1:0] pending_nxt;
   int                 cf;

   // The door-entry clear is applied last so it beats a same-cycle call on that floor.
   always_comb begin
      set_mask = call_req;
      if (ign_en) set_mask[cur_floor] = 1'b0;
      pending_nxt = pending | set_mask;
      if (clr_en) pending_nxt[clr_idx] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= pending_nxt;
   end

   // above_next/below_next look past the floor the car is about to reach.
   always_comb begin
      cf         = int'(cur_floor);
      above      = 1'b0;
      below      = 1'b0;
      above_next = 1'b0;
      below_next = 1'b0;
      for (int i = 0; i < NFLOORS; i++) begin
         if (i > cf)     above      = above | pending[i];
         if (i < cf)     below      = below | pending[i];
         if (i > cf + 1) above_next = above_next | pending[i];
         if (i < cf - 1) below_next = below_next | pending[i];
      end
   end

endmodule

// File: rtl/lift_call_scheduler.sv
// SCAN-ordered lift car sequencer with a movement watchdog and sticky fault.
module lift_call_scheduler
   import lift_pkg::*;
#(
   parameter int NFLOORS      = NFLOORS_DEF,
   parameter int MOVE_TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NFLOORS-1:0]         call_req,
   input  logic                       arrive,
   input  logic                       door_done,
   output logic                       move_up,
   output logic                       move_down,
   output logic                       door_open,
   output logic [$clog2(NFLOORS)-1:0] cur_floor,
   output logic [NFLOORS-1:0]         pending,
   output logic                       busy,
   output logic                       fault
);

   localparam int FLW = $clog2(NFLOORS);
   localparam int WDW = $clog2(MOVE_TIMEOUT + 1);
   localparam logic [FLW-1:0] TOP_FLOOR = FLW'(NFLOORS - 1);
   localparam logic [WDW-1:0] WD_LAST   = WDW'(MOVE_TIMEOUT - 1);

   lift_state_t    state, state_nxt;
   logic [FLW-1:0] floor_nxt;
   logic           dir_up, dir_nxt;
   logic [WDW-1:0] wdog;
   logic           above, below, above_next, below_next;
   logic           clr_en, ign_en;

   lift_call_latch #(.NFLOORS(NFLOORS), .FLW(FLW)) u_latch (
      .clk        (clk),
      .rst        (rst),
      .call_req   (call_req),
      .cur_floor  (cur_floor),
      .ign_en     (ign_en),
      .clr_en     (clr_en),
      .clr_idx    (floor_nxt),
      .pending    (pending),
      .above      (above),
      .below      (below),
      .above_next (above_next),
      .below_next (below_next)
   );

   // An arrive pulse beats a watchdog expiry in the same cycle.
   always_comb begin
      state_nxt = state;
      floor_nxt = cur_floor;
      dir_nxt   = dir_up;
      case (state)
         IDLE: begin
            if (pending[cur_floor]) begin
               state_nxt = DOOR;
            end else if (above && (dir_up || !below)) begin
               state_nxt = MOVE_UP;
               dir_nxt   = DIR_UP;
            end else if (below) begin
               state_nxt = MOVE_DOWN;
               dir_nxt   = DIR_DOWN;
            end
         end
         MOVE_UP: begin
            if (arrive) begin
               if (cur_floor == TOP_FLOOR) begin
                  state_nxt = IDLE;
               end else begin
                  floor_nxt = cur_floor + 1'b1;
                  if (pending[floor_nxt]) state_nxt = DOOR;
                  else if (above_next)    state_nxt = MOVE_UP;
                  else                    state_nxt = IDLE;
               end
            end else if (wdog == WD_LAST) begin
               state_nxt = FAULT;
            end
         end
         MOVE_DOWN: begin
            if (arrive) begin
               if (cur_floor == '0) begin
                  state_nxt = IDLE;
               end else begin
                  floor_nxt = cur_floor - 1'b1;
                  if (pending[floor_nxt]) state_nxt = DOOR;
                  else if (below_next)    state_nxt = MOVE_DOWN;
                  else                    state_nxt = IDLE;
               end
            end else if (wdog == WD_LAST) begin
               state_nxt = FAULT;
            end
         end
         DOOR: begin
            if (door_done) state_nxt = IDLE;
         end
         FAULT: state_nxt = FAULT;
         default: state_nxt = IDLE;
      endcase
      clr_en = (state_nxt == DOOR) && (state != DOOR);
      ign_en = (state == DOOR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_floor <= '0;
         dir_up    <= DIR_UP;
         wdog      <= '0;
         move_up   <= 1'b0;
         move_down <= 1'b0;
         door_open <= 1'b0;
         busy      <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cur_floor <= floor_nxt;
         dir_up    <= dir_nxt;
         if ((state == MOVE_UP || state == MOVE_DOWN) && state_nxt == state && !arrive)
            wdog <= wdog + 1'b1;
         else
            wdog <= '0;
         move_up   <= (state_nxt == MOVE_UP);
         move_down <= (state_nxt == MOVE_DOWN);
         door_open <= (state_nxt == DOOR);
         busy      <= (state_nxt != IDLE);
         fault     <= (state_nxt == FAULT);
      end
   end

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Vector-table and scoreboard bench for lift_call_scheduler (NFLOORS=8, MOVE_TIMEOUT=16).
module tb_lift_call_scheduler;

   localparam int NF = 8;
   localparam int TO = 16;

   localparam logic [4:0] C_IDLE = 5'b00000;
   localparam logic [4:0] C_UP   = 5'b01001;
   localparam logic [4:0] C_DN   = 5'b01010;
   localparam logic [4:0] C_DR   = 5'b01100;
   localparam logic [4:0] C_FLT  = 5'b11000;

   logic          clk = 1'b0;
   logic          rst;
   logic [NF-1:0] call_req;
   logic          arrive;
   logic          door_done;
   logic          move_up, move_down, door_open, busy, fault;
   logic [2:0]    cur_floor;
   logic [NF-1:0] pending;

   // cmd packs {fault, busy, door_open, move_down, move_up}
   typedef struct {
      string      name;
      logic       rst;
      logic [7:0] call;
      logic       arr;
      logic       dd;
      logic [7:0] pend;
      logic [2:0] floor;
      logic [4:0] cmd;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   lift_call_scheduler #(.NFLOORS(NF), .MOVE_TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .call_req  (call_req),
      .arrive    (arrive),
      .door_done (door_done),
      .move_up   (move_up),
      .move_down (move_down),
      .door_open (door_open),
      .cur_floor (cur_floor),
      .pending   (pending),
      .busy      (busy),
      .fault     (fault)
   );

   function automatic vec_t mk(string n, logic r, logic [7:0] c, logic a, logic d,
                               logic [7:0] p, logic [2:0] f, logic [4:0] cm);
      vec_t v;
      v.name = n; v.rst = r; v.call = c; v.arr = a; v.dd = d;
      v.pend = p; v.floor = f; v.cmd = cm;
      return v;
   endfunction

   task automatic checkOutput();
      vec_t       e;
      logic [4:0] cmd_act;
      e       = sb.pop_front();
      cmd_act = {fault, busy, door_open, move_down, move_up};
      checks++;
      if ({pending, cur_floor, cmd_act} !== {e.pend, e.floor, e.cmd}) begin
         failures++;
         $display("[TB] FAIL %s @%0t: got pend=%h floor=%0d cmd=%b, want pend=%h floor=%0d cmd=%b",
                  e.name, $time, pending, cur_floor, cmd_act, e.pend, e.floor, e.cmd);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst       = v.rst;
      call_req  = v.call;
      arrive    = v.arr;
      door_done = v.dd;
      sb.push_back(v);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst = 1'b1; call_req = '0; arrive = 1'b0; door_done = 1'b0;

      // reset, then a call at the current floor
      tbl.push_back(mk("reset",       1, 8'h00, 0, 0, 8'h00, 0, C_IDLE));
      tbl.push_back(mk("f0_call",     0, 8'h01, 0, 0, 8'h01, 0, C_IDLE));
      tbl.push_back(mk("f0_door",     0, 8'h00, 0, 0, 8'h00, 0, C_DR));
      tbl.push_back(mk("f0_hold",     0, 8'h00, 0, 0, 8'h00, 0, C_DR));
      tbl.push_back(mk("f0_done",     0, 8'h00, 0, 1, 8'h00, 0, C_IDLE));
      // single trip to floor 5
      tbl.push_back(mk("up5_call",    0, 8'h20, 0, 0, 8'h20, 0, C_IDLE));
      tbl.push_back(mk("up5_start",   0, 8'h00, 0, 0, 8'h20, 0, C_UP));
      tbl.push_back(mk("up5_arr1",    0, 8'h00, 1, 0, 8'h20, 1, C_UP));
      tbl.push_back(mk("up5_arr2",    0, 8'h00, 1, 0, 8'h20, 2, C_UP));
      tbl.push_back(mk("up5_arr3",    0, 8'h00, 1, 0, 8'h20, 3, C_UP));
      tbl.push_back(mk("up5_arr4",    0, 8'h00, 1, 0, 8'h20, 4, C_UP));
      tbl.push_back(mk("up5_arr5",    0, 8'h00, 1, 0, 8'h00, 5, C_DR));
      tbl.push_back(mk("up5_done",    0, 8'h00, 0, 1, 8'h00, 5, C_IDLE));
      // SCAN: reach floor 3 going up, then calls at 1 and 6
      tbl.push_back(mk("scan_rst",    1, 8'h00, 0, 0, 8'h00, 0, C_IDLE));
      tbl.push_back(mk("scan_c3",     0, 8'h08, 0, 0, 8'h08, 0, C_IDLE));
      tbl.push_back(mk("scan_go3",    0, 8'h00, 0, 0, 8'h08, 0, C_UP));
      tbl.push_back(mk("scan_a1",     0, 8'h00, 1, 0, 8'h08, 1, C_UP));
      tbl.push_back(mk("scan_a2",     0, 8'h00, 1, 0, 8'h08, 2, C_UP));
      tbl.push_back(mk("scan_a3",     0, 8'h00, 1, 0, 8'h00, 3, C_DR));
      tbl.push_back(mk("scan_d3",     0, 8'h00, 0, 1, 8'h00, 3, C_IDLE));
      tbl.push_back(mk("scan_c16",    0, 8'h42, 0, 0, 8'h42, 3, C_IDLE));
      tbl.push_back(mk("scan_up",     0, 8'h00, 0, 0, 8'h42, 3, C_UP));
      tbl.push_back(mk("scan_a4",     0, 8'h00, 1, 0, 8'h42, 4, C_UP));
      tbl.push_back(mk("scan_a5",     0, 8'h00, 1, 0, 8'h42, 5, C_UP));
      tbl.push_back(mk("scan_a6",     0, 8'h00, 1, 0, 8'h02, 6, C_DR));
      tbl.push_back(mk("scan_d6",     0, 8'h00, 0, 1, 8'h02, 6, C_IDLE));
      tbl.push_back(mk("scan_down",   0, 8'h00, 0, 0, 8'h02, 6, C_DN));
      tbl.push_back(mk("scan_b5",     0, 8'h00, 1, 0, 8'h02, 5, C_DN));
      tbl.push_back(mk("scan_b4",     0, 8'h00, 1, 0, 8'h02, 4, C_DN));
      tbl.push_back(mk("scan_b3",     0, 8'h00, 1, 0, 8'h02, 3, C_DN));
      tbl.push_back(mk("scan_b2",     0, 8'h00, 1, 0, 8'h02, 2, C_DN));
      tbl.push_back(mk("scan_b1",     0, 8'h00, 1, 0, 8'h00, 1, C_DR));
      tbl.push_back(mk("scan_d1",     0, 8'h00, 0, 1, 8'h00, 1, C_IDLE));
      // call during door, arrive ignored in DOOR/IDLE, clear beats same-cycle call
      tbl.push_back(mk("dr_c4",       0, 8'h10, 0, 0, 8'h10, 1, C_IDLE));
      tbl.push_back(mk("dr_up",       0, 8'h00, 0, 0, 8'h10, 1, C_UP));
      tbl.push_back(mk("dr_a2",       0, 8'h00, 1, 0, 8'h10, 2, C_UP));
      tbl.push_back(mk("dr_a3",       0, 8'h00, 1, 0, 8'h10, 3, C_UP));
      tbl.push_back(mk("dr_a4",       0, 8'h00, 1, 0, 8'h00, 4, C_DR));
      tbl.push_back(mk("dr_call_in",  0, 8'h90, 1, 0, 8'h80, 4, C_DR));
      tbl.push_back(mk("dr_done",     0, 8'h00, 0, 1, 8'h80, 4, C_IDLE));
      tbl.push_back(mk("dr_up7",      0, 8'h00, 0, 0, 8'h80, 4, C_UP));
      tbl.push_back(mk("dr_a5",       0, 8'h00, 1, 0, 8'h80, 5, C_UP));
      tbl.push_back(mk("dr_a6",       0, 8'h00, 1, 0, 8'h80, 6, C_UP));
      tbl.push_back(mk("clr_wins",    0, 8'h80, 1, 0, 8'h00, 7, C_DR));
      tbl.push_back(mk("dr_d7",       0, 8'h00, 0, 1, 8'h00, 7, C_IDLE));
      tbl.push_back(mk("idle_arr",    0, 8'h00, 1, 0, 8'h00, 7, C_IDLE));
      // reset mid-move at floor 2
      tbl.push_back(mk("rm_c0",       0, 8'h01, 0, 0, 8'h01, 7, C_IDLE));
      tbl.push_back(mk("rm_down",     0, 8'h00, 0, 0, 8'h01, 7, C_DN));
      tbl.push_back(mk("rm_b6",       0, 8'h00, 1, 0, 8'h01, 6, C_DN));
      tbl.push_back(mk("rm_b5",       0, 8'h00, 1, 0, 8'h01, 5, C_DN));
      tbl.push_back(mk("rm_b4",       0, 8'h00, 1, 0, 8'h01, 4, C_DN));
      tbl.push_back(mk("rm_b3",       0, 8'h00, 1, 0, 8'h01, 3, C_DN));
      tbl.push_back(mk("rm_b2",       0, 8'h00, 1, 0, 8'h01, 2, C_DN));
      tbl.push_back(mk("rm_reset",    1, 8'h40, 0, 0, 8'h00, 0, C_IDLE));

      foreach (tbl[i]) applyStimulus(tbl[i]);

      // watchdog trips exactly TO cycles after move_up rises
      applyStimulus(mk("wd_c1",    0, 8'h02, 0, 0, 8'h02, 0, C_IDLE));
      applyStimulus(mk("wd_up",    0, 8'h00, 0, 0, 8'h02, 0, C_UP));
      for (int i = 1; i < TO; i++)
         applyStimulus(mk("wd_run", 0, 8'h00, 0, 0, 8'h02, 0, C_UP));
      applyStimulus(mk("wd_trip",  0, 8'h00, 0, 0, 8'h02, 0, C_FLT));
      applyStimulus(mk("flt_arr",  0, 8'h00, 1, 0, 8'h02, 0, C_FLT));
      applyStimulus(mk("flt_call", 0, 8'h08, 0, 0, 8'h0A, 0, C_FLT));
      applyStimulus(mk("flt_dd",   0, 8'h00, 0, 1, 8'h0A, 0, C_FLT));
      applyStimulus(mk("flt_rst",  1, 8'h00, 0, 0, 8'h00, 0, C_IDLE));

      // arrive on the expiry cycle beats the timeout
      applyStimulus(mk("wa_c2",    0, 8'h04, 0, 0, 8'h04, 0, C_IDLE));
      applyStimulus(mk("wa_up",    0, 8'h00, 0, 0, 8'h04, 0, C_UP));
      for (int i = 1; i < TO; i++)
         applyStimulus(mk("wa_run", 0, 8'h00, 0, 0, 8'h04, 0, C_UP));
      applyStimulus(mk("wa_edge",  0, 8'h00, 1, 0, 8'h04, 1, C_UP));
      applyStimulus(mk("wa_a2",    0, 8'h00, 1, 0, 8'h00, 2, C_DR));
      applyStimulus(mk("wa_done",  0, 8'h00, 0, 1, 8'h00, 2, C_IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
